branch_predict_unit: RTL and testbench

// - Successor to the ID-stage combinational branch decision: adds a BHT of 2-bit saturating counters indexed by IF PC.
// - IF side predicts conditional branches. ID side resolves them with SIGNED compares and drives PC select and IF flush.
// - A mispredict is corrected from ID; the wrong-path IF instruction is flushed.
// - Sits between the IF PC mux and the ID register-read/compare logic of the 5-stage MIPS core.

---
 rtl/branch_predict_unit.sv | 191 +++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// IF-side 2-bit BHT branch predictor with ID-side signed branch resolution and mispredict recovery.
// Define BRANCH_STATS_EN to add branch / mispredict statistics counters.
module branch_predict_unit #(
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [1:0]  CNT_INIT  = 2'b01
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned STAT_W    = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic [5:0]  op,
    input  logic [4:0]  rt_field,
    input  logic [5:0]  func,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [2:0]  pc_src,
    output logic        if_flush,
    output logic        mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
`endif
);

    localparam int unsigned BHT_SIZE = 2 ** BHT_IDX_W;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RI_BLTZ    = 5'b00000;
    localparam logic [4:0] RI_BGEZ    = 5'b00001;
    localparam logic [4:0] RI_BLTZAL  = 5'b10000;
    localparam logic [4:0] RI_BGEZAL  = 5'b10001;

    localparam logic [2:0] PC_SEQ     = 3'b000;
    localparam logic [2:0] PC_JUMP    = 3'b001;
    localparam logic [2:0] PC_BR_TGT  = 3'b010;
    localparam logic [2:0] PC_JREG    = 3'b011;
    localparam logic [2:0] PC_PRED    = 3'b100;
    localparam logic [2:0] PC_RECOVER = 3'b101;

    function automatic logic is_cond_branch(input logic [5:0] opc, input logic [4:0] sub);
        logic r;
        r = 1'b0;
        case (opc)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: r = 1'b1;
            OP_REGIMM:
                r = (sub == RI_BLTZ) || (sub == RI_BGEZ) ||
                    (sub == RI_BLTZAL) || (sub == RI_BGEZAL);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]           bht [BHT_SIZE];
    logic [BHT_IDX_W-1:0] if_idx;
    logic                 if_cond;
    logic                 unused_if_rs;

    logic                 pv;
    logic                 ptaken;
    logic [BHT_IDX_W-1:0] pidx;

    logic                 res_en;
    logic                 id_cond;
    logic                 id_actual;
    logic                 bht_we;
    logic [1:0]           cur_cnt;
    logic [1:0]           next_cnt;

    // ---------------- IF side: prediction ----------------
    assign if_idx       = if_pc[BHT_IDX_W+1:2];
    assign if_cond      = is_cond_branch(if_instr[31:26], if_instr[20:16]);
    assign unused_if_rs = ^if_instr[25:21];

    assign pred_taken  = !rst && if_valid && if_cond && bht[if_idx][1];
    assign pred_target = if_pc + 32'd4 + {{14{if_instr[15]}}, if_instr[15:0], 2'b00};

    // IF->ID prediction register; a flush kills the entry even while stalled
    always_ff @(posedge clk) begin
        if (rst || if_flush) begin
            pv <= 1'b0;
        end else if (!stall) begin
            pv <= if_valid;
        end

        if (rst) begin
            ptaken <= 1'b0;
            pidx   <= '0;
        end else if (!stall) begin
            ptaken <= pred_taken;
            pidx   <= if_idx;
        end
    end

    // ---------------- ID side: resolution ----------------
    assign res_en  = id_valid && pv && !rst;
    assign id_cond = is_cond_branch(op, rt_field);

    always_comb begin
        id_actual = 1'b0;
        case (op)
            OP_BEQ:    id_actual = (rs == rt);
            OP_BNE:    id_actual = (rs != rt);
            OP_BLEZ:   id_actual = ($signed(rs) <= 32'sd0);
            OP_BGTZ:   id_actual = ($signed(rs) >  32'sd0);
            OP_REGIMM: id_actual = rt_field[0] ? ($signed(rs) >= 32'sd0)
                                               : ($signed(rs) <  32'sd0);
            default:   id_actual = 1'b0;
        endcase
    end

    // ID redirects take priority over the IF prediction
    always_comb begin
        pc_src     = pred_taken ? PC_PRED : PC_SEQ;
        if_flush   = 1'b0;
        mispredict = 1'b0;
        bht_we     = 1'b0;
        if (res_en) begin
            if (op == OP_J || op == OP_JAL) begin
                pc_src   = PC_JUMP;
                if_flush = 1'b1;
            end else if (op == OP_SPECIAL && (func == FN_JR || func == FN_JALR)) begin
                pc_src   = PC_JREG;
                if_flush = 1'b1;
            end else if (id_cond) begin
                bht_we = !stall;
                if (id_actual && !ptaken) begin
                    pc_src     = PC_BR_TGT;
                    if_flush   = 1'b1;
                    mispredict = 1'b1;
                end else if (!id_actual && ptaken) begin
                    pc_src     = PC_RECOVER;
                    if_flush   = 1'b1;
                    mispredict = 1'b1;
                end
            end
        end
    end

    // ---------------- BHT training ----------------
    assign cur_cnt = bht[pidx];

    always_comb begin
        if (id_actual) begin
            next_cnt = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'd1;
        end else begin
            next_cnt = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht <= '{default: CNT_INIT};
        end else if (bht_we) begin
            bht[pidx] <= next_cnt;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (bht_we) begin
            stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit: a pipeline is emulated step by step,
// expected outputs are queued per step and popped/compared at the falling edge.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic [5:0]  op;
    logic [4:0]  rt_field;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  pc_src;
    logic        if_flush;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(
        .BHT_IDX_W (6),
        .CNT_INIT  (2'b01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .id_valid    (id_valid),
        .op          (op),
        .rt_field    (rt_field),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .pc_src      (pc_src),
        .if_flush    (if_flush),
        .mispredict  (mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // IF instruction words; targets are pc+4+(imm<<2)
    localparam logic [31:0] I_BEQ_40  = {6'b000100, 5'd1, 5'd2, 16'h0003}; // @0x40 -> 0x50
    localparam logic [31:0] I_BGEZ_40 = {6'b000001, 5'd1, 5'd1, 16'h0003}; // @0x40 -> 0x50
    localparam logic [31:0] I_ADDI_44 = {6'b001000, 5'd1, 5'd2, 16'h0010}; // @0x44 -> 0x88
    localparam logic [31:0] I_BNE_80  = {6'b000101, 5'd1, 5'd2, 16'hFFFE}; // @0x80 -> 0x7C
    localparam logic [31:0] I_BGEZ_80 = {6'b000001, 5'd1, 5'd1, 16'hFFFE};
    localparam logic [31:0] I_BGTZ_80 = {6'b000111, 5'd1, 5'd0, 16'hFFFE};
    localparam logic [31:0] I_BLEZ_80 = {6'b000110, 5'd1, 5'd0, 16'hFFFE};

    typedef struct {
        string       tag;
        logic        pt;
        logic [31:0] tgt;
        logic [2:0]  ps;
        logic        fl;
        logic        mp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
    endtask

    task automatic set_id(input logic v, input logic [5:0] o, input logic [4:0] rf,
                          input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        id_valid = v;
        op       = o;
        rt_field = rf;
        func     = fn;
        rs       = a;
        rt       = b;
    endtask

    task automatic push(input string tag, input logic pt, input logic [31:0] tgt,
                        input logic [2:0] ps, input logic fl, input logic mp);
        exp_t e;
        e.tag = tag;
        e.pt  = pt;
        e.tgt = tgt;
        e.ps  = ps;
        e.fl  = fl;
        e.mp  = mp;
        sb.push_back(e);
    endtask

    task automatic check_step();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_underflow: observed 0 entries expected >0");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, e.pt});
            cmp({e.tag, ".pred_target"}, pred_target,         e.tgt);
            cmp({e.tag, ".pc_src"},      {29'd0, pc_src},     {29'd0, e.ps});
            cmp({e.tag, ".if_flush"},    {31'd0, if_flush},   {31'd0, e.fl});
            cmp({e.tag, ".mispredict"},  {31'd0, mispredict}, {31'd0, e.mp});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held across two edges; ID carries a jr that must be ignored.
        rst = 1'b1; stall = 1'b0;
        set_if(1, 32'h40, I_BEQ_40); set_id(1, OP_SPECIAL, 5'd0, 6'b001000, 0, 0);
        push("s00_rst", 0, 32'h50, 3'b000, 0, 0); check_step();

        rst = 1'b0;
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s01_beq_if_cold", 0, 32'h50, 3'b000, 0, 0); check_step();
        set_if(1, 32'h44, I_ADDI_44); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 5);
        push("s02_beq_id_mis_taken", 0, 32'h88, 3'b010, 1, 1); check_step();

        // Counter 01->10: now predicted taken
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s03_beq_if_pred", 1, 32'h50, 3'b100, 0, 0); check_step();
        set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 5);
        push("s04_beq_id_hit", 0, 32'h50, 3'b000, 0, 0); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s05_beq_if_pred", 1, 32'h50, 3'b100, 0, 0); check_step();
        set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 7, 7);
        push("s06_beq_id_sat", 0, 32'h50, 3'b000, 0, 0); check_step();

        // bgez with rs=-1 is signed not-taken: recover to ID pc+4, counter 11->10
        set_if(1, 32'h40, I_BGEZ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s07_bgez_if_pred", 1, 32'h50, 3'b100, 0, 0); check_step();
        set_if(0, 32'h40, I_BGEZ_40); set_id(1, OP_REGIMM, 5'd1, 6'd0, 32'hFFFF_FFFF, 0);
        push("s08_bgez_id_recover", 0, 32'h50, 3'b101, 1, 1); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s09_beq_if_ctr10", 1, 32'h50, 3'b100, 0, 0); check_step();
        set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 6);
        push("s10_beq_id_recover", 0, 32'h50, 3'b101, 1, 1); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s11_beq_if_ctr01", 0, 32'h50, 3'b000, 0, 0); check_step();

        // jr under stall: redirect still driven, BHT untouched
        stall = 1'b1;
        set_if(1, 32'h80, I_BNE_80); set_id(1, OP_SPECIAL, 5'd0, 6'b001000, 0, 0);
        push("s12_jr_stall", 0, 32'h7C, 3'b011, 1, 0); check_step();
        stall = 1'b0;
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s13_beq_if_after_jr", 0, 32'h50, 3'b000, 0, 0); check_step();

        // Stall holds the beq@0x40 entry; the bgez@0x80 load is blocked
        stall = 1'b1;
        set_if(1, 32'h80, I_BGEZ_80); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s14_if_load_blocked", 0, 32'h7C, 3'b000, 0, 0); check_step();
        stall = 1'b0;
        set_if(0, 32'h80, I_BGEZ_80); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 5);
        push("s15_held_beq_mis", 0, 32'h7C, 3'b010, 1, 1); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s16_idx40_trained", 1, 32'h50, 3'b100, 0, 0); check_step();

        // Correctly predicted branch stalled three cycles, then one update
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 5);
            push("s17_stall_hold", 0, 32'h50, 3'b000, 0, 0); check_step();
        end
        stall = 1'b0;
        set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 5);
        push("s20_stall_release", 0, 32'h50, 3'b000, 0, 0); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s21_beq_if_pred", 1, 32'h50, 3'b100, 0, 0); check_step();
        set_if(0, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 6);
        push("s22_beq_id_recover", 0, 32'h50, 3'b101, 1, 1); check_step();
        // Still taken only if the released branch trained 10->11
        set_if(1, 32'h40, I_BEQ_40); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s23_ctr_after_stall", 1, 32'h50, 3'b100, 0, 0); check_step();

        // Reset with a mispredicting branch in ID
        rst = 1'b1;
        set_if(1, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 6);
        push("s24_rst_mis_in_id", 0, 32'h50, 3'b000, 0, 0); check_step();
        rst = 1'b0;
        set_if(1, 32'h40, I_BEQ_40); set_id(1, OP_BEQ, 5'd2, 6'd0, 5, 6);
        push("s25_post_rst_init", 0, 32'h50, 3'b000, 0, 0); check_step();
        set_if(1, 32'h80, I_BGTZ_80); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s26_bgtz_if", 0, 32'h7C, 3'b000, 0, 0); check_step();
        set_if(1, 32'h40, I_BEQ_40); set_id(1, OP_J, 5'd0, 6'd0, 0, 0);
        push("s27_j_redirect", 0, 32'h50, 3'b001, 1, 0); check_step();

        // Signed bgtz/blez at 0x80
        set_if(1, 32'h80, I_BGTZ_80); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s28_bgtz_if", 0, 32'h7C, 3'b000, 0, 0); check_step();
        set_if(0, 32'h80, I_BGTZ_80); set_id(1, OP_BGTZ, 5'd0, 6'd0, 32'h8000_0000, 0);
        push("s29_bgtz_neg_nt", 0, 32'h7C, 3'b000, 0, 0); check_step();
        set_if(1, 32'h80, I_BLEZ_80); set_id(0, OP_BEQ, 5'd2, 6'd0, 0, 0);
        push("s30_blez_if", 0, 32'h7C, 3'b000, 0, 0); check_step();
        set_if(0, 32'h80, I_BLEZ_80); set_id(1, OP_BLEZ, 5'd0, 6'd0, 0, 0);
        push("s31_blez_zero_taken", 0, 32'h7C, 3'b010, 1, 1); check_step();

        cmp("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
